rr_mux_arb: RTL and testbench

//  N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.

---
 rtl/rr_mux_arb.sv | 146 ++++++++++++++
 tb/tb_rr_mux_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with valid/ready handshakes on every port.
// One requesting channel is granted per cycle, round-robin or fixed priority.
module rr_mux_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CHANNELS*WIDTH-1:0] d_i,
  input  logic [CHANNELS-1:0]       d_valid_i,
  output logic [CHANNELS-1:0]       d_ready_o,
  input  logic                      mode_i,
  output logic [WIDTH-1:0]          y_o,
  output logic [SEL_W-1:0]          y_sel_o,
  output logic                      y_valid_o,
  input  logic                      y_ready_i
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;

  logic                 gnt_any_s;
  logic [SEL_W-1:0]     gnt_idx_s;
  logic [CHANNELS-1:0]  gnt_s;
  logic [WIDTH-1:0]     gnt_data_s;
  logic                 load_s;
  logic                 xfer_in_s;

  // Search for the first requester, starting at the pointer (round-robin) or at channel 0
  always_comb begin : arb_comb
    logic [SEL_W:0] cand;
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    cand      = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      if (mode_i) begin
        cand = (SEL_W+1)'(off);
      end else begin
        cand = {1'b0, ptr_q} + (SEL_W+1)'(off);
        if (cand >= (SEL_W+1)'(CHANNELS)) begin
          cand = cand - (SEL_W+1)'(CHANNELS);
        end else begin
          cand = cand;
        end
      end
      if (!gnt_any_s && d_valid_i[cand[SEL_W-1:0]]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = cand[SEL_W-1:0];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Data word of the granted channel
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx_s == SEL_W'(i)) begin
        gnt_data_s = d_i[i*WIDTH +: WIDTH];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // Grant vector and handshake qualifiers
  always_comb begin
    if (gnt_any_s) begin
      gnt_s = CHANNELS'(1) << gnt_idx_s;
    end else begin
      gnt_s = '0;
    end
    load_s    = (state_q == ST_EMPTY) | y_ready_i;
    xfer_in_s = gnt_any_s & load_s;
    d_ready_o = gnt_s & {CHANNELS{load_s & rst_ni}};
  end

  // Output register state machine and pointer update
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer_in_s) begin
      y_d   = gnt_data_s;
      sel_d = gnt_idx_s;
      if (!mode_i) begin
        if (gnt_idx_s == SEL_W'(CHANNELS-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gnt_idx_s + SEL_W'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (gnt_any_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (y_ready_i && !gnt_any_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, output and pointer registers; a word in flight is dropped on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y_o       = y_q;
  assign y_sel_o   = sel_q;
  assign y_valid_o = (state_q == ST_FULL);

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: hand-checked vectors plus a per-cycle
// comparison against a behavioural arbitration model.
module tb_rr_mux_arb;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [CH*W-1:0] d;
  logic [CH-1:0]   d_valid;
  logic [CH-1:0]   d_ready;
  logic            mode;
  logic [W-1:0]    y;
  logic [SW-1:0]   y_sel;
  logic            y_valid;
  logic            y_ready;

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux_arb #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .d_i       (d),
    .d_valid_i (d_valid),
    .d_ready_o (d_ready),
    .mode_i    (mode),
    .y_o       (y),
    .y_sel_o   (y_sel),
    .y_valid_o (y_valid),
    .y_ready_i (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: output register contents and round-robin pointer
  logic [W-1:0] m_y;
  int           m_sel;
  bit           m_valid;
  int           m_ptr;

  always @(negedge clk) begin : cmp
    int         win;
    int         c;
    bit         load;
    logic [CH-1:0] exp_ready;
    if (!rst_n) begin
      m_y = '0; m_sel = 0; m_valid = 1'b0; m_ptr = 0;
      chk("rst_y", 64'(y), 64'(0));
      chk("rst_y_valid", 64'(y_valid), 64'(0));
      chk("rst_d_ready", 64'(d_ready), 64'(0));
    end else begin
      chk("mdl_y", 64'(y), 64'(m_y));
      chk("mdl_y_sel", 64'(y_sel), 64'(m_sel));
      chk("mdl_y_valid", 64'(y_valid), 64'(m_valid));
      win = -1;
      for (int j = 0; j < CH; j++) begin
        c = mode ? j : (m_ptr + j) % CH;
        if (win < 0 && d_valid[c]) win = c;
      end
      load = !m_valid || y_ready;
      exp_ready = (load && win >= 0) ? CH'(1 << win) : '0;
      chk("mdl_d_ready", 64'(d_ready), 64'(exp_ready));
      if (load) begin
        if (win >= 0) begin
          m_y = d[win*W +: W];
          m_sel = win;
          m_valid = 1'b1;
          if (!mode) m_ptr = (win + 1) % CH;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    d[ch*W +: W] = v;
  endtask

  initial begin
    rst_n = 1'b1; d = '0; d_valid = '0; mode = 1'b0; y_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    // 1: reset state, then release with no requests
    chk("t1_y", 64'(y), 64'(0));
    chk("t1_y_valid", 64'(y_valid), 64'(0));
    chk("t1_d_ready", 64'(d_ready), 64'(0));
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("t1_idle_valid", 64'(y_valid), 64'(0));
    chk("t1_idle_ready", 64'(d_ready), 64'(0));

    // 2: round-robin, all channels valid, sink always ready
    for (int i = 0; i < CH; i++) set_ch(i, W'(32'hA0 + i));
    d_valid = 4'b1111; mode = 1'b0; y_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t2_sel", 64'(y_sel), 64'(k % 4));
      chk("t2_y", 64'(y), 64'(32'hA0 + (k % 4)));
      chk("t2_valid", 64'(y_valid), 64'(1));
    end
    d_valid = 4'b0000;
    cyc();
    chk("t2_drain", 64'(y_valid), 64'(0));

    // 3: fixed priority, channels 1 and 3 requesting
    mode = 1'b1; set_ch(1, 32'hB1); set_ch(3, 32'hB3); d_valid = 4'b1010;
    #1 chk("t3_ready0", 64'(d_ready), 64'(4'b0010));
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_sel", 64'(y_sel), 64'(1));
      chk("t3_y", 64'(y), 64'(32'hB1));
      chk("t3_ready", 64'(d_ready), 64'(4'b0010));
    end

    // 4: hold 32'hDEAD under backpressure, then reload with no bubble
    set_ch(0, 32'hDEAD); d_valid = 4'b0001;
    cyc();
    chk("t4_y", 64'(y), 64'(32'hDEAD));
    y_ready = 1'b0; set_ch(1, 32'hC1); set_ch(2, 32'hC2); set_ch(3, 32'hC3);
    d_valid = 4'b1110;
    #1 chk("t4_ready_blk0", 64'(d_ready), 64'(0));
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t4_hold_y", 64'(y), 64'(32'hDEAD));
      chk("t4_hold_valid", 64'(y_valid), 64'(1));
      chk("t4_ready_blk", 64'(d_ready), 64'(0));
    end
    y_ready = 1'b1;
    #1 chk("t4_ready_go", 64'(d_ready), 64'(4'b0010));
    cyc();
    chk("t4_next_y", 64'(y), 64'(32'hC1));
    chk("t4_next_valid", 64'(y_valid), 64'(1));

    // 5: pointer wrap (pointer is still 0 after the fixed-priority phase)
    mode = 1'b0; d_valid = 4'b0100;
    cyc();
    chk("t5_sel2", 64'(y_sel), 64'(2));
    set_ch(0, 32'hE0); set_ch(3, 32'hE3); d_valid = 4'b0001;
    #1 chk("t5_ready_wrap", 64'(d_ready), 64'(4'b0001));
    cyc();
    chk("t5_sel0", 64'(y_sel), 64'(0));
    d_valid = 4'b1001;
    #1 chk("t5_ptr1", 64'(d_ready), 64'(4'b1000));
    cyc();
    chk("t5_sel3", 64'(y_sel), 64'(3));
    #1 chk("t5_ptr0", 64'(d_ready), 64'(4'b0001));
    cyc();
    chk("t5_sel0b", 64'(y_sel), 64'(0));
    chk("t5_y_e0", 64'(y), 64'(32'hE0));

    // 6: asynchronous reset pulse while a word is held
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 64'(y_valid), 64'(0));
    chk("t6_y_async", 64'(y), 64'(0));
    chk("t6_sel_async", 64'(y_sel), 64'(0));
    chk("t6_ready_async", 64'(d_ready), 64'(0));
    cyc();
    rst_n = 1'b1;
    #1 chk("t6_restart", 64'(d_ready), 64'(4'b0001));
    cyc();
    chk("t6_sel", 64'(y_sel), 64'(0));
    chk("t6_y", 64'(y), 64'(32'hE0));

    d_valid = '0;
    repeat (3) cyc();
    chk("end_idle", 64'(y_valid), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
